ifu_pc_gen: RTL and testbench
=============================

Name: ifu_pc_gen

Overview:
- Program-counter generation stage directly upstream of the instruction fetch stage; drives the address that fetch passes to the instruction bus.
- Advances PC sequentially. Applies branch and trap redirects with fixed priority.
- Holds the PC stable while the fetch bus is busy or decode stalls.
- Defers redirects that arrive during a busy fetch and flags the in-flight wrong-path instruction for kill.

Parameters:
- ADDR_LEN, 32, PC width in bits (matches `ADDR_LEN)
- RESET_VEC, 32'h0000_0000, first fetch address after reset
- PC_INC, 4, sequential PC increment in bytes

Ports:
- clk  input  1  core clock, rising edge
- rst_  input  1  asynchronous reset, active-low
- wait_  input  1  from fetch stage; 0 = fetch bus busy (current PC access not complete), 1 = access completes this cycle
- stall_i  input  1  downstream (decode) hold request, active-high
- redirect_en_i  input  1  branch/jump redirect request, single-cycle pulse
- redirect_pc_i  input  ADDR_LEN  branch/jump target
- trap_en_i  input  1  trap/exception redirect request, single-cycle pulse
- trap_pc_i  input  ADDR_LEN  trap vector
- pc_o  output  ADDR_LEN  current fetch address, registered
- fetch_req_o  output  1  fetch address valid, registered
- inst_kill_o  output  1  instruction returned this cycle is wrong-path and must be converted to nop, combinational

Behaviour:
- Reset (rst_ low, asynchronous):
  - pc_o = RESET_VEC, fetch_req_o = 0, state = BOOT.
  - Pending-redirect storage is cleared (pend_vld = 0, pend_trap = 0).
  - Reset mid-operation discards any pending redirect.
- State BOOT: the first clock edge after reset release moves to RUN and sets fetch_req_o = 1. pc_o stays at RESET_VEC.
- Target alignment: all redirect targets have bits [1:0] forced to 0 before use.
- Redirect priority in the same cycle: trap_en_i > redirect_en_i > sequential advance > hold.
- State RUN:
  - advance = fetch_req_o & wait_ & ~stall_i.
  - If trap_en_i or redirect_en_i and wait_ = 1: pc_o <= selected target next edge, regardless of stall_i. State remains RUN.
  - If trap_en_i or redirect_en_i and wait_ = 0: pc_o holds, since the bus address must stay stable during an access. pend_pc <= target, pend_vld <= 1, pend_trap <= trap_en_i. State goes to HOLD.
  - Otherwise, if advance: pc_o <= pc_o + PC_INC, truncated to ADDR_LEN so it wraps 0xFFFF_FFFC -> 0x0000_0000.
  - Otherwise pc_o holds.
- State HOLD:
  - pc_o holds while wait_ = 0.
  - A new trap_en_i overwrites pend_pc and sets pend_trap = 1.
  - A new redirect_en_i overwrites pend_pc only if pend_trap = 0; if pend_trap = 1 it is ignored.
  - On a cycle with wait_ = 1: pc_o <= pend_pc (or the new trap/redirect target if one arrives that same cycle, using the rules above). pend_vld <= 0, pend_trap <= 0, state goes to RUN.
  - stall_i is ignored in HOLD: the redirect wins.
- inst_kill_o = (state == HOLD) | trap_en_i | redirect_en_i. It is 0 in BOOT and during reset.
- Latency:
  - Redirect with a non-busy fetch: new pc_o visible 1 cycle after the request.
  - Redirect with a busy fetch: new pc_o visible 1 cycle after the cycle in which wait_ = 1.
- fetch_req_o stays 1 from the end of BOOT until the next reset.

Test Plan:
- Reset release with RESET_VEC = 0x100, wait_ = 1, stall_i = 0:
  - pc_o = 0x100 and fetch_req_o = 0 during reset.
  - After the first edge, fetch_req_o = 1 and pc_o = 0x100.
  - pc_o then steps 0x104, 0x108, 0x10C on successive cycles.
- Sequential run with stall_i = 1 for 3 cycles at pc_o = 0x200: pc_o holds 0x200 for 3 cycles, then 0x204. Repeat with wait_ = 0 for 2 cycles: same hold.
- redirect_en_i with redirect_pc_i = 0x403 and wait_ = 1 at pc_o = 0x208:
  - inst_kill_o = 1 that cycle.
  - Next cycle pc_o = 0x400, then 0x404.
- Busy-fetch redirect: wait_ = 0 for 3 cycles; redirect to 0x800 in cycle 1; trap to 0x40 in cycle 2; redirect to 0x900 in cycle 3; wait_ = 1 in cycle 4.
  - pc_o is unchanged through cycle 4.
  - inst_kill_o = 1 in cycles 1-4.
  - pc_o = 0x40 in cycle 5; inst_kill_o = 0 in cycle 5.
- Simultaneous trap_en_i (0x40) and redirect_en_i (0x800) with wait_ = 1 and stall_i = 1: next pc_o = 0x40.
- Wrap and reset-in-HOLD:
  - From pc_o = 0xFFFF_FFFC, advance gives pc_o = 0x0.
  - Enter HOLD with pending 0x800, then assert rst_ low: pc_o = RESET_VEC immediately and fetch_req_o = 0.
  - After reset release, pc_o never takes 0x800.

Source files
------------

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: program-counter generation stage in front of instruction fetch.
// Advances the PC sequentially, applies trap and branch redirects (trap wins),
// and keeps the bus address stable while a fetch is outstanding. A redirect
// that arrives during a busy fetch is parked and applied when the access ends.
// The instruction returned in the meantime is flagged for kill.
module ifu_pc_gen #(
    parameter int                  ADDR_LEN  = 32,
    parameter logic [ADDR_LEN-1:0] RESET_VEC = '0,
    parameter int                  PC_INC    = 4
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                wait_,
    input  logic                stall_i,
    input  logic                redirect_en_i,
    input  logic [ADDR_LEN-1:0] redirect_pc_i,
    input  logic                trap_en_i,
    input  logic [ADDR_LEN-1:0] trap_pc_i,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic                fetch_req_o,
    output logic                inst_kill_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_LEN-1:0] INC        = ADDR_LEN'(PC_INC);
    localparam logic [ADDR_LEN-1:0] ALIGN_MASK = ~ADDR_LEN'(3);

    state_t              state;
    logic [ADDR_LEN-1:0] pend_pc;
    logic                pend_vld;
    logic                pend_trap;

    logic [ADDR_LEN-1:0] trap_tgt;
    logic [ADDR_LEN-1:0] redir_tgt;
    logic [ADDR_LEN-1:0] live_tgt;
    logic                live_req;
    logic                advance;

    // Word-align redirect targets and pick the highest-priority live request.
    always_comb begin
        trap_tgt  = trap_pc_i & ALIGN_MASK;
        redir_tgt = redirect_pc_i & ALIGN_MASK;
        live_req  = trap_en_i | redirect_en_i;
        live_tgt  = trap_en_i ? trap_tgt : redir_tgt;
        advance   = fetch_req_o & wait_ & ~stall_i;
    end

    // PC, fetch-valid and pending-redirect state; redirects win over stall.
    // NOTE: every register here uses <= so all of them see the pre-edge values
    // of each other; a blocking = would let later lines read updated state.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= BOOT;
            pc_o        <= RESET_VEC;
            fetch_req_o <= 1'b0;
            // NOTE: pend_pc is reset as well even though pend_vld guards it, so a
            // reset in HOLD can never leak a stale target into the next run.
            pend_pc     <= '0;
            pend_vld    <= 1'b0;
            pend_trap   <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_req_o <= 1'b1;
                end

                RUN: begin
                    if (live_req) begin
                        if (wait_) begin
                            pc_o <= live_tgt;
                        end else begin
                            // Bus address must stay put; park the target.
                            pend_pc   <= live_tgt;
                            pend_vld  <= 1'b1;
                            pend_trap <= trap_en_i;
                            state     <= HOLD;
                        end
                    end else if (advance) begin
                        pc_o <= pc_o + INC;
                    end
                end

                HOLD: begin
                    if (wait_) begin
                        if (trap_en_i) begin
                            pc_o <= trap_tgt;
                        end else if (redirect_en_i && !pend_trap) begin
                            pc_o <= redir_tgt;
                        end else begin
                            pc_o <= pend_pc;
                        end
                        pend_vld  <= 1'b0;
                        pend_trap <= 1'b0;
                        state     <= RUN;
                    end else if (trap_en_i) begin
                        pend_pc   <= trap_tgt;
                        pend_trap <= 1'b1;
                    end else if (redirect_en_i && !pend_trap) begin
                        // A parked trap outranks any later branch.
                        pend_pc <= redir_tgt;
                    end
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    // Kill the returning instruction while a redirect is parked (pend_vld is
    // set exactly while in HOLD) or whenever a live redirect arrives after BOOT.
    always_comb begin
        inst_kill_o = pend_vld | ((state != BOOT) & live_req);
    end

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Self-checking bench for ifu_pc_gen: directed vector table, reset-in-HOLD
// sequence, then randomized traffic against a rule-level reference model.
module tb_ifu_pc_gen;

    localparam logic [31:0] RVEC = 32'h0000_0100;

    logic        clk;
    logic        rst_;
    logic        wait_;
    logic        stall_i;
    logic        redirect_en_i;
    logic [31:0] redirect_pc_i;
    logic        trap_en_i;
    logic [31:0] trap_pc_i;
    logic [31:0] pc_o;
    logic        fetch_req_o;
    logic        inst_kill_o;

    int checks = 0;
    int errors = 0;

    ifu_pc_gen #(
        .ADDR_LEN (32),
        .RESET_VEC(RVEC),
        .PC_INC   (4)
    ) dut (
        .clk          (clk),
        .rst_         (rst_),
        .wait_        (wait_),
        .stall_i      (stall_i),
        .redirect_en_i(redirect_en_i),
        .redirect_pc_i(redirect_pc_i),
        .trap_en_i    (trap_en_i),
        .trap_pc_i    (trap_pc_i),
        .pc_o         (pc_o),
        .fetch_req_o  (fetch_req_o),
        .inst_kill_o  (inst_kill_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (rule level) ----------------
    bit          m_booted;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_pend_trap;

    function automatic void model_reset();
        m_booted    = 0;
        m_pc        = RVEC;
        m_pend      = 0;
        m_pend_pc   = '0;
        m_pend_trap = 0;
    endfunction

    function automatic bit model_kill(bit te, bit re);
        return m_booted && (m_pend || te || re);
    endfunction

    function automatic void model_step(bit w, bit s, bit re, logic [31:0] rpc,
                                       bit te, logic [31:0] tpc);
        logic [31:0] t_al;
        logic [31:0] r_al;
        t_al = {tpc[31:2], 2'b00};
        r_al = {rpc[31:2], 2'b00};
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_pend) begin
            if (w) begin
                if (te)                      m_pc = t_al;
                else if (re && !m_pend_trap) m_pc = r_al;
                else                         m_pc = m_pend_pc;
                m_pend      = 0;
                m_pend_trap = 0;
            end else if (te) begin
                m_pend_pc   = t_al;
                m_pend_trap = 1;
            end else if (re && !m_pend_trap) begin
                m_pend_pc = r_al;
            end
        end else if (te || re) begin
            if (w) begin
                m_pc = te ? t_al : r_al;
            end else begin
                m_pend      = 1;
                m_pend_pc   = te ? t_al : r_al;
                m_pend_trap = te;
            end
        end else if (w && !s) begin
            m_pc = m_pc + 32'd4;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (caller sits just after a rising edge), check
    // the combinational kill mid-cycle, then clock and check the registered PC.
    task automatic run_cycle(input bit w, input bit s, input bit re, input logic [31:0] rpc,
                             input bit te, input logic [31:0] tpc,
                             output logic [31:0] got_pc, output logic got_kill);
        wait_         = w;
        stall_i       = s;
        redirect_en_i = re;
        redirect_pc_i = rpc;
        trap_en_i     = te;
        trap_pc_i     = tpc;
        #2;
        got_kill = inst_kill_o;
        check("kill_vs_model", {31'd0, inst_kill_o}, {31'd0, model_kill(te, re)});
        @(posedge clk);
        model_step(w, s, re, rpc, te, tpc);
        #1;
        got_pc = pc_o;
        check("pc_vs_model", pc_o, m_pc);
        check("fetch_req_vs_model", {31'd0, fetch_req_o}, {31'd0, m_booted});
    endtask

    typedef struct {
        bit          w;
        bit          s;
        bit          re;
        logic [31:0] rpc;
        bit          te;
        logic [31:0] tpc;
        logic [31:0] exp_pc;
        bit          exp_kill;
    } vec_t;

    function automatic vec_t mk(bit w, bit s, bit re, logic [31:0] rpc, bit te,
                                logic [31:0] tpc, logic [31:0] exp_pc, bit exp_kill);
        vec_t v;
        v.w = w; v.s = s; v.re = re; v.rpc = rpc; v.te = te; v.tpc = tpc;
        v.exp_pc = exp_pc; v.exp_kill = exp_kill;
        return v;
    endfunction

    vec_t        tbl[$];
    logic [31:0] gpc;
    logic        gkill;

    initial begin
        // Directed table: inputs for a cycle, PC expected after its edge, kill during it.
        tbl.push_back(mk(1,0,0,0,0,0, 32'h104, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 32'h108, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 32'h10C, 0));
        tbl.push_back(mk(1,0,1,32'h200,0,0, 32'h200, 1));
        tbl.push_back(mk(1,1,0,0,0,0, 32'h200, 0));          // stall x3
        tbl.push_back(mk(1,1,0,0,0,0, 32'h200, 0));
        tbl.push_back(mk(1,1,0,0,0,0, 32'h200, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 32'h204, 0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h204, 0));          // busy x2
        tbl.push_back(mk(0,0,0,0,0,0, 32'h204, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 32'h208, 0));
        tbl.push_back(mk(1,0,1,32'h403,0,0, 32'h400, 1));    // misaligned target
        tbl.push_back(mk(1,0,0,0,0,0, 32'h404, 0));
        tbl.push_back(mk(0,0,1,32'h800,0,0, 32'h404, 1));    // busy redirect
        tbl.push_back(mk(0,0,0,0,1,32'h40, 32'h404, 1));     // trap overrides
        tbl.push_back(mk(0,0,1,32'h900,0,0, 32'h404, 1));    // ignored behind trap
        tbl.push_back(mk(1,0,0,0,0,0, 32'h040, 1));
        tbl.push_back(mk(1,0,0,0,0,0, 32'h044, 0));
        tbl.push_back(mk(1,1,1,32'h800,1,32'h40, 32'h040, 1)); // trap beats branch and stall
        tbl.push_back(mk(1,0,0,0,0,0, 32'h044, 0));
        tbl.push_back(mk(0,0,1,32'h500,0,0, 32'h044, 1));
        tbl.push_back(mk(1,0,1,32'h602,0,0, 32'h600, 1));    // newer branch on release
        tbl.push_back(mk(0,0,0,0,1,32'h81, 32'h600, 1));
        tbl.push_back(mk(1,1,1,32'h700,0,0, 32'h080, 1));    // parked trap wins
        tbl.push_back(mk(1,0,0,0,0,0, 32'h084, 0));
        tbl.push_back(mk(1,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 1));
        tbl.push_back(mk(1,0,0,0,0,0, 32'h000, 0));          // wrap
        tbl.push_back(mk(1,0,0,0,0,0, 32'h004, 0));

        // Reset state.
        model_reset();
        rst_ = 1'b0; wait_ = 1'b1; stall_i = 1'b0;
        redirect_en_i = 1'b0; redirect_pc_i = '0; trap_en_i = 1'b0; trap_pc_i = '0;
        #12;
        check("reset_pc", pc_o, RVEC);
        check("reset_fetch_req", {31'd0, fetch_req_o}, 32'd0);
        check("reset_kill", {31'd0, inst_kill_o}, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        model_step(1, 0, 0, 0, 0, 0);
        #1;
        check("boot_pc", pc_o, RVEC);
        check("boot_fetch_req", {31'd0, fetch_req_o}, 32'd1);

        // Directed table.
        foreach (tbl[i]) begin
            run_cycle(tbl[i].w, tbl[i].s, tbl[i].re, tbl[i].rpc, tbl[i].te, tbl[i].tpc, gpc, gkill);
            check($sformatf("tbl%0d_pc", i), gpc, tbl[i].exp_pc);
            check($sformatf("tbl%0d_kill", i), {31'd0, gkill}, {31'd0, tbl[i].exp_kill});
        end

        // Reset while a redirect is parked.
        run_cycle(0, 0, 1, 32'h800, 0, 0, gpc, gkill);
        check("hold_entry_pc", gpc, 32'h004);
        wait_ = 1'b0; redirect_en_i = 1'b0;
        #2;
        rst_ = 1'b0;
        model_reset();
        #1;
        check("midrst_pc", pc_o, RVEC);
        check("midrst_fetch_req", {31'd0, fetch_req_o}, 32'd0);
        check("midrst_kill", {31'd0, inst_kill_o}, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1, 0, 0, 0, 0, 0, gpc, gkill);
            if (gpc == 32'h800) check("no_stale_target", gpc, 32'h0);
        end
        check("post_reset_pc", gpc, RVEC + 32'd28);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            run_cycle(($urandom % 4) != 0, ($urandom % 4) == 0,
                      ($urandom % 6) == 0, $urandom,
                      ($urandom % 12) == 0, $urandom, gpc, gkill);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
